// File: rtl/indexed_address_unit.sv
// Effective-address generator for the 6502 indexed modes, including the
// zero-page pointer fetches of (zp,X) and (zp),Y and page-cross reporting.
module indexed_address_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic               is_store,
  input  logic [WIDTH-1:0]   op_lo,
  input  logic [WIDTH-1:0]   op_hi,
  input  logic [WIDTH-1:0]   x_value,
  input  logic [WIDTH-1:0]   y_value,
  output logic [2*WIDTH-1:0] mem_addr,
  output logic               mem_rd,
  input  logic [WIDTH-1:0]   mem_data,
  output logic [2*WIDTH-1:0] ea,
  output logic               ea_valid,
  output logic               page_cross,
  output logic               busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PTR_LO = 3'd1;
  localparam logic [2:0] PTR_HI = 3'd2;
  localparam logic [2:0] FIXUP  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [2:0] MODE_ZPX = 3'b000;
  localparam logic [2:0] MODE_ZPY = 3'b001;
  localparam logic [2:0] MODE_ABX = 3'b010;
  localparam logic [2:0] MODE_ABY = 3'b011;
  localparam logic [2:0] MODE_IZX = 3'b100;
  localparam logic [2:0] MODE_IZY = 3'b101;

  logic [2:0]       state;
  logic             indy_r;
  logic             store_r;
  logic [WIDTH-1:0] ptr_r;
  logic [WIDTH-1:0] idx_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] sel_idx;
  logic [WIDTH-1:0] ptr_next;
  logic [WIDTH:0]   start_sum;
  logic [WIDTH:0]   post_sum;
  logic             req_ok;

  // Odd modes index with Y, even modes with X; the extra sum bit is the page carry.
  always_comb begin
    sel_idx   = mode[0] ? y_value : x_value;
    start_sum = {1'b0, op_lo} + {1'b0, sel_idx};
    post_sum  = {1'b0, lo_r} + {1'b0, idx_r};
    ptr_next  = WIDTH'(ptr_r + 1'b1);
    req_ok    = start && (mode[2:1] != 2'b11);
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    busy     = 1'b0;
    ea_valid = 1'b0;
    if (!reset) begin
      busy     = (state != IDLE);
      ea_valid = (state == DONE);
      if (state == PTR_LO) begin
        mem_rd   = 1'b1;
        mem_addr = {{WIDTH{1'b0}}, ptr_r};
      end else if (state == PTR_HI) begin
        mem_rd   = 1'b1;
        mem_addr = {{WIDTH{1'b0}}, ptr_next};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ea         <= '0;
      page_cross <= 1'b0;
      indy_r     <= 1'b0;
      store_r    <= 1'b0;
      ptr_r      <= '0;
      idx_r      <= '0;
      lo_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            store_r <= is_store;
            indy_r  <= (mode == MODE_IZY);
            idx_r   <= y_value;
            case (mode)
              MODE_ZPX, MODE_ZPY: begin
                ea         <= {{WIDTH{1'b0}}, start_sum[WIDTH-1:0]};
                page_cross <= 1'b0;
                state      <= DONE;
              end
              MODE_ABX, MODE_ABY: begin
                ea         <= {op_hi + WIDTH'(start_sum[WIDTH]), start_sum[WIDTH-1:0]};
                page_cross <= start_sum[WIDTH];
                state      <= (start_sum[WIDTH] || is_store) ? FIXUP : DONE;
              end
              MODE_IZX: begin
                ptr_r <= start_sum[WIDTH-1:0];
                state <= PTR_LO;
              end
              MODE_IZY: begin
                ptr_r <= op_lo;
                state <= PTR_LO;
              end
              default: state <= IDLE;
            endcase
          end
        end
        PTR_LO: begin
          lo_r  <= mem_data;
          state <= PTR_HI;
        end
        // (zp),Y applies the index to the fetched pointer; (zp,X) uses it as-is.
        PTR_HI: begin
          if (indy_r) begin
            ea         <= {mem_data + WIDTH'(post_sum[WIDTH]), post_sum[WIDTH-1:0]};
            page_cross <= post_sum[WIDTH];
            state      <= (post_sum[WIDTH] || store_r) ? FIXUP : DONE;
          end else begin
            ea         <= {mem_data, lo_r};
            page_cross <= 1'b0;
            state      <= DONE;
          end
        end
        FIXUP:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_indexed_address_unit.sv
// Scoreboard bench for indexed_address_unit: expected results are queued as
// requests are issued and popped when ea_valid appears.
module tb_indexed_address_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic        is_store;
  logic [7:0]  op_lo;
  logic [7:0]  op_hi;
  logic [7:0]  x_value;
  logic [7:0]  y_value;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [15:0] ea;
  logic        ea_valid;
  logic        page_cross;
  logic        busy;

  logic [7:0] zp_mem [256];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       nm;
    logic [2:0]  m;
    logic        st;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  xv;
    logic [7:0]  yv;
    logic [15:0] ea;
    logic        pc;
    int          lat;
    int          nrd;
    logic [15:0] r0;
    logic [15:0] r1;
  } req_t;

  typedef struct {
    logic        seen;
    logic [15:0] ea;
    logic        pc;
    int          lat;
    int          nrd;
    logic [15:0] r0;
    logic [15:0] r1;
  } obs_t;

  req_t sb[$];

  indexed_address_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .is_store(is_store),
    .op_lo(op_lo), .op_hi(op_hi), .x_value(x_value), .y_value(y_value),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = zp_mem[mem_addr[7:0]];

  // Drive one request so the start edge is the next rising edge, then return in cycle 1.
  task automatic issue(input req_t r);
    @(negedge clk);
    mode = r.m; is_store = r.st; op_lo = r.lo; op_hi = r.hi;
    x_value = r.xv; y_value = r.yv; start = 1'b1;
    sb.push_back(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watch from cycle 1 until ea_valid (bounded), then step into the following cycle.
  task automatic observe(output obs_t o);
    o.seen = 1'b0; o.ea = '0; o.pc = 1'b0; o.lat = 0; o.nrd = 0; o.r0 = '0; o.r1 = '0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_rd === 1'b1) begin
        if (o.nrd == 0) o.r0 = mem_addr;
        else o.r1 = mem_addr;
        o.nrd++;
      end
      if (ea_valid === 1'b1) begin
        o.seen = 1'b1; o.lat = c; o.ea = ea; o.pc = page_cross;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; mode = 3'b000; is_store = 1'b0;
    op_lo = 8'hF0; op_hi = 8'h00; x_value = 8'h20; y_value = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (ea !== 16'h0000) begin fails++; $display("[TB] FAIL reset_ea got %h want 0000", ea); end
    tests++; if (ea_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_ea_valid got %b want 0", ea_valid); end
    tests++; if (page_cross !== 1'b0) begin fails++; $display("[TB] FAIL reset_page_cross got %b want 0", page_cross); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_rd got %b want 0", mem_rd); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("[TB] FAIL reset_mem_addr got %h want 0000", mem_addr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_zp;
    req_t rq [3];
    obs_t o;
    req_t e;
    rq[0] = '{"zpx_wrap", 3'b000, 1'b0, 8'hF0, 8'h00, 8'h20, 8'h99, 16'h0010, 1'b0, 1, 0, 16'h0, 16'h0};
    rq[1] = '{"zpy_sel",  3'b001, 1'b0, 8'h7F, 8'hAA, 8'h55, 8'h01, 16'h0080, 1'b0, 1, 0, 16'h0, 16'h0};
    rq[2] = '{"zpx_store",3'b000, 1'b1, 8'h10, 8'h33, 8'h05, 8'h80, 16'h0015, 1'b0, 1, 0, 16'h0, 16'h0};
    for (int i = 0; i < 3; i++) begin
      issue(rq[i]);
      observe(o);
      e = sb.pop_front();
      tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
      tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
      tests++; if (o.pc !== e.pc) begin fails++; $display("[TB] FAIL %s page_cross got %b want %b", e.nm, o.pc, e.pc); end
      tests++; if (o.nrd != e.nrd) begin fails++; $display("[TB] FAIL %s reads got %0d want %0d", e.nm, o.nrd, e.nrd); end
    end
  endtask

  task automatic test_abs;
    req_t rq [4];
    obs_t o;
    req_t e;
    rq[0] = '{"absy_load",  3'b011, 1'b0, 8'hF0, 8'h12, 8'h77, 8'h05, 16'h12F5, 1'b0, 1, 0, 16'h0, 16'h0};
    rq[1] = '{"absy_carry", 3'b011, 1'b0, 8'hF0, 8'h12, 8'h77, 8'h20, 16'h1310, 1'b1, 2, 0, 16'h0, 16'h0};
    rq[2] = '{"absy_store", 3'b011, 1'b1, 8'hF0, 8'h12, 8'h77, 8'h05, 16'h12F5, 1'b0, 2, 0, 16'h0, 16'h0};
    rq[3] = '{"absx_wrap",  3'b010, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'h77, 16'h0000, 1'b1, 2, 0, 16'h0, 16'h0};
    for (int i = 0; i < 4; i++) begin
      issue(rq[i]);
      observe(o);
      e = sb.pop_front();
      tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
      tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
      tests++; if (o.pc !== e.pc) begin fails++; $display("[TB] FAIL %s page_cross got %b want %b", e.nm, o.pc, e.pc); end
      tests++; if (o.nrd != e.nrd) begin fails++; $display("[TB] FAIL %s reads got %0d want %0d", e.nm, o.nrd, e.nrd); end
    end
  endtask

  task automatic test_indirect;
    req_t rq [4];
    obs_t o;
    req_t e;
    rq[0] = '{"izy_carry", 3'b101, 1'b0, 8'h40, 8'h00, 8'h09, 8'h01, 16'h2100, 1'b1, 4, 2, 16'h0040, 16'h0041};
    rq[1] = '{"izx_wrap",  3'b100, 1'b0, 8'hFE, 8'h00, 8'h01, 8'h07, 16'h1234, 1'b0, 3, 2, 16'h00FF, 16'h0000};
    rq[2] = '{"izy_load",  3'b101, 1'b0, 8'h40, 8'h00, 8'h09, 8'h00, 16'h20FF, 1'b0, 3, 2, 16'h0040, 16'h0041};
    rq[3] = '{"izy_store", 3'b101, 1'b1, 8'h40, 8'h00, 8'h09, 8'h00, 16'h20FF, 1'b0, 4, 2, 16'h0040, 16'h0041};
    for (int i = 0; i < 4; i++) begin
      issue(rq[i]);
      observe(o);
      e = sb.pop_front();
      tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
      tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
      tests++; if (o.pc !== e.pc) begin fails++; $display("[TB] FAIL %s page_cross got %b want %b", e.nm, o.pc, e.pc); end
      tests++; if (o.nrd != e.nrd || o.r0 !== e.r0 || o.r1 !== e.r1) begin
        fails++; $display("[TB] FAIL %s reads got %0d %h %h want %0d %h %h", e.nm, o.nrd, o.r0, o.r1, e.nrd, e.r0, e.r1);
      end
    end
  endtask

  task automatic test_back_to_back;
    req_t rq [3];
    obs_t o;
    req_t e;
    rq[0] = '{"b2b_zpx",  3'b000, 1'b0, 8'h01, 8'h00, 8'h02, 8'h00, 16'h0003, 1'b0, 1, 0, 16'h0, 16'h0};
    rq[1] = '{"b2b_izx",  3'b100, 1'b0, 8'hFD, 8'h00, 8'h02, 8'h00, 16'h1234, 1'b0, 3, 2, 16'h00FF, 16'h0000};
    rq[2] = '{"b2b_absx", 3'b010, 1'b0, 8'h10, 8'hAB, 8'h0F, 8'h00, 16'hAB1F, 1'b0, 1, 0, 16'h0, 16'h0};
    for (int i = 0; i < 3; i++) begin
      issue(rq[i]);
      observe(o);
      e = sb.pop_front();
      tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
      tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
      tests++; if (o.nrd != e.nrd || o.r0 !== e.r0 || o.r1 !== e.r1) begin
        fails++; $display("[TB] FAIL %s reads got %0d %h %h want %0d %h %h", e.nm, o.nrd, o.r0, o.r1, e.nrd, e.r0, e.r1);
      end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL %s busy_after_done got %b want 0", e.nm, busy); end
    end
  endtask

  // Inputs change, start stays high while busy, then a reserved mode is offered in IDLE.
  task automatic test_ignore;
    req_t r;
    obs_t o;
    req_t e;
    r = '{"ignore_absx", 3'b010, 1'b0, 8'hF0, 8'h12, 8'h20, 8'h00, 16'h1310, 1'b1, 2, 0, 16'h0, 16'h0};
    issue(r);
    start = 1'b1; x_value = 8'h00; op_lo = 8'h00; op_hi = 8'h55; mode = 3'b110;
    observe(o);
    e = sb.pop_front();
    tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
    tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
    tests++; if (o.pc !== e.pc) begin fails++; $display("[TB] FAIL %s page_cross got %b want %b", e.nm, o.pc, e.pc); end
    for (int c = 0; c < 3; c++) begin
      tests++; if (busy !== 1'b0 || ea_valid !== 1'b0) begin fails++; $display("[TB] FAIL reserved_mode busy/ea_valid got %b/%b want 0/0", busy, ea_valid); end
      tests++; if (ea !== 16'h1310 || page_cross !== 1'b1) begin fails++; $display("[TB] FAIL hold_result got %h/%b want 1310/1", ea, page_cross); end
      @(posedge clk); #1;
    end
    mode = 3'b111;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reserved_mode_111 busy got %b want 0", busy); end
    start = 1'b0;
  endtask

  task automatic test_reset_abort;
    req_t r;
    obs_t o;
    req_t e;
    r = '{"abort_izy", 3'b101, 1'b0, 8'h40, 8'h00, 8'h00, 8'h01, 16'h2100, 1'b1, 4, 2, 16'h0040, 16'h0041};
    issue(r);
    e = sb.pop_front();
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin fails++; $display("[TB] FAIL abort_ptr_lo got %b/%h want 1/0040", mem_rd, mem_addr); end
    @(posedge clk); #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0041) begin fails++; $display("[TB] FAIL abort_ptr_hi got %b/%h want 1/0041", mem_rd, mem_addr); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++; if (mem_rd !== 1'b0 || busy !== 1'b0 || ea_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL abort_after_reset rd/busy/valid got %b/%b/%b want 0/0/0", mem_rd, busy, ea_valid);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++; if (ea_valid !== 1'b0 || mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL abort_quiet valid/rd got %b/%b want 0/0", ea_valid, mem_rd); end
    end
    r = '{"post_abort_zpy", 3'b001, 1'b0, 8'h80, 8'h00, 8'h11, 8'h90, 16'h0010, 1'b0, 1, 0, 16'h0, 16'h0};
    issue(r);
    observe(o);
    e = sb.pop_front();
    tests++; if (o.seen !== 1'b1 || o.lat != e.lat) begin fails++; $display("[TB] FAIL %s latency got %0d (seen %b) want %0d", e.nm, o.lat, o.seen, e.lat); end
    tests++; if (o.ea !== e.ea) begin fails++; $display("[TB] FAIL %s ea got %h want %h", e.nm, o.ea, e.ea); end
    tests++; if (o.pc !== e.pc) begin fails++; $display("[TB] FAIL %s page_cross got %b want %b", e.nm, o.pc, e.pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) zp_mem[i] = 8'(i ^ 8'hA5);
    zp_mem[8'hFF] = 8'h34;
    zp_mem[8'h00] = 8'h12;
    zp_mem[8'h40] = 8'hFF;
    zp_mem[8'h41] = 8'h20;
    reset = 1'b1; start = 1'b0; mode = 3'b000; is_store = 1'b0;
    op_lo = 8'h00; op_hi = 8'h00; x_value = 8'h00; y_value = 8'h00;
    test_reset();
    test_zp();
    test_abs();
    test_indirect();
    test_back_to_back();
    test_ignore();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/indexed_address_unit.md
# indexed_address_unit

Computes the 16-bit effective address for the 6502 indexed addressing modes (zp,X; zp,Y; abs,X; abs,Y; (zp,X); (zp),Y). It sits directly downstream of the X and Y index registers, consuming their latched register values. It also performs the zero-page pointer reads needed by the indirect modes. It reports page crossings so the sequencer can account for the extra cycle.

## Interface
- WIDTH, 8, data/index width; address is 2*WIDTH.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  3  000 zp,X; 001 zp,Y; 010 abs,X; 011 abs,Y; 100 (zp,X); 101 (zp),Y; 11x reserved.
- is_store  input  1  store instruction: forces the fixup cycle on abs/(zp),Y.
- op_lo  input  WIDTH  first operand byte.
- op_hi  input  WIDTH  second operand byte; used by abs modes only.
- x_value  input  WIDTH  X register value.
- y_value  input  WIDTH  Y register value.
- mem_addr  output  2*WIDTH  pointer read address.
- mem_rd  output  1  pointer read strobe.
- mem_data  input  WIDTH  read data; valid in the same cycle as mem_rd (asynchronous-read memory).
- ea  output  2*WIDTH  effective address (registered).
- ea_valid  output  1  one-cycle pulse: ea is final.
- page_cross  output  1  carry out of the low-byte index add; valid with ea_valid.
- busy  output  1  state != IDLE.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, PTR_LO, PTR_HI, FIXUP, DONE.
- Input capture: at the edge where start=1 in IDLE with a valid mode, capture mode, is_store, op_lo, op_hi and the selected index. Later changes to these inputs are ignored.
- Reserved mode, or start while busy: request ignored, no state change.
- zp,X / zp,Y:
  - ea = {00, (op_lo+idx) mod 256}; the address wraps within page zero.
  - IDLE→DONE; page_cross=0.
- abs,X / abs,Y:
  - sum = op_lo + idx (WIDTH+1 bits); c = carry out.
  - ea = {op_hi + c, sum[7:0]}; a 16-bit wrap is permitted (FFFF+1 → 0000).
  - page_cross = c.
  - IDLE→FIXUP if c or is_store, else IDLE→DONE.
- (zp,X):
  - p = (op_lo+X) mod 256; IDLE→PTR_LO.
  - PTR_LO: mem_addr={00,p}, mem_rd=1, capture lo; →PTR_HI.
  - PTR_HI: mem_addr={00,(p+1) mod 256}, mem_rd=1, capture hi; →DONE.
  - ea = {hi, lo}; page_cross=0.
- (zp),Y:
  - p = op_lo; PTR_LO/PTR_HI as for (zp,X), including the zero-page wrap for p+1.
  - In PTR_HI: sum = lo + Y; ea = {hi + c, sum[7:0]}; page_cross = c.
  - PTR_HI→FIXUP if c or is_store, else PTR_HI→DONE.
- FIXUP: no memory access; →DONE.
- DONE: ea_valid=1; →IDLE.
- mem_rd=1 only in PTR_LO/PTR_HI. mem_addr=0 in all other states.
- Reset values: state IDLE; ea=0000, ea_valid=0, page_cross=0, mem_rd=0, mem_addr=0000, busy=0.
- Reset mid-operation: the operation is aborted with no further mem_rd and no ea_valid. The next cycle is IDLE.
- ea and page_cross hold their last values after DONE until the next result.

## Timing
- Cycle 1 is the cycle after the start edge. ea_valid occurs:
  - zp,X / zp,Y: cycle 1.
  - abs no carry and load: cycle 1.
  - abs with carry or store: cycle 2.
  - (zp,X): cycle 3.
  - (zp),Y no carry and load: cycle 3; with carry or store: cycle 4.
- Pointer reads: PTR_LO in cycle 1, PTR_HI in cycle 2.
- busy rises in cycle 1 and falls the cycle after DONE.
- Back-to-back: the earliest next start is sampled in the IDLE cycle following DONE.

## Test plan
- Reset, then zp,X with op_lo=F0, X=20 → ea=0010, page_cross=0, ea_valid in cycle 1. All outputs are 0 during reset.
- abs,Y load with op=12F0, Y=05 → ea=12F5 in cycle 1. Repeat with Y=20 → ea=1310, page_cross=1, cycle 2. Repeat with Y=05 and is_store=1 → ea=12F5, page_cross=0, cycle 2.
- (zp,X) with op_lo=FE, X=01, mem[00FF]=34, mem[0000]=12 → reads 00FF then 0000, ea=1234, cycle 3.
- (zp),Y with op_lo=40, mem[0040]=FF, mem[0041]=20, Y=01 → ea=2100, page_cross=1, cycle 4. Repeat with Y=00 → ea=20FF, cycle 3.
- Change x_value/op_lo after start; assert start while busy; use mode 110 → result unaffected; extra starts and the reserved mode are ignored.
- Assert reset in PTR_HI of a (zp),Y operation → no ea_valid, mem_rd=0 next cycle, busy=0. A new request afterwards completes normally.
